// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN scheduler for an eight-floor car.
// Tracks the car floor and outstanding requests, drives the motor one floor
// per FLOOR_TICK and holds the door open for DOOR_CYCLES at each stop.

module elevator_scheduler #(
  parameter int unsigned DOOR_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ_VALID,
  input  logic [2:0] REQ_FLOOR,
  input  logic       FLOOR_TICK,
  output logic       MOTOR_UP,
  output logic       MOTOR_DOWN,
  output logic       DOOR_OPEN,
  output logic [2:0] CUR_FLOOR,
  output logic [7:0] PENDING,
  output logic [1:0] STATE
);

  localparam int unsigned FLOOR_W    = 3;
  localparam int unsigned NUM_FLOORS = 8;
  localparam int unsigned TIMER_W    = 8;

  localparam logic [FLOOR_W-1:0]    TOP_FLOOR    = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0]    BOTTOM_FLOOR = FLOOR_W'(0);
  localparam logic [TIMER_W-1:0]    DOOR_LOAD    = TIMER_W'(DOOR_CYCLES);
  localparam logic [NUM_FLOORS-1:0] FLOOR0_BIT   = NUM_FLOORS'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } state_t;

  state_t                  state_q,      state_d;
  logic [FLOOR_W-1:0]      cur_floor_q,  cur_floor_d;
  logic [NUM_FLOORS-1:0]   pending_q,    pending_d;
  logic                    dir_q,        dir_d;
  logic [TIMER_W-1:0]      timer_q,      timer_d;
  logic                    motor_up_q,   motor_up_d;
  logic                    motor_down_q, motor_down_d;
  logic                    door_open_q,  door_open_d;

  logic [NUM_FLOORS-1:0]   req_bit;
  logic [NUM_FLOORS-1:0]   merged;
  logic [NUM_FLOORS-1:0]   above_mask;
  logic [NUM_FLOORS-1:0]   below_mask;
  logic                    req_here;
  logic                    any_above;
  logic                    any_below;
  logic [FLOOR_W-1:0]      floor_up;
  logic [FLOOR_W-1:0]      floor_down;

  // Request decode and floor-relative views of the pending bitmap
  always_comb begin
    req_bit    = '0;
    above_mask = '0;
    below_mask = '0;
    if (REQ_VALID) begin
      req_bit = FLOOR0_BIT << REQ_FLOOR;
    end
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      above_mask[i] = (FLOOR_W'(i) > cur_floor_q);
      below_mask[i] = (FLOOR_W'(i) < cur_floor_q);
    end
    req_here   = REQ_VALID && (REQ_FLOOR == cur_floor_q);
    merged     = pending_q | req_bit;
    any_above  = |(pending_q & above_mask);
    any_below  = |(pending_q & below_mask);
    floor_up   = cur_floor_q + FLOOR_W'(1);
    floor_down = cur_floor_q - FLOOR_W'(1);
  end

  // Next-state, request capture, floor stepping and door timer
  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    pending_d   = pending_q;
    dir_d       = dir_q;
    timer_d     = timer_q;

    unique case (state_q)
      IDLE: begin
        if (req_here) begin
          // A call at the car's own floor just opens the door
          state_d = DOOR;
          timer_d = DOOR_LOAD;
        end else begin
          pending_d = merged;
          if (pending_q != '0) begin
            if (dir_q && any_above) begin
              state_d = MOVE_UP;
              dir_d   = 1'b1;
            end else if (any_below) begin
              state_d = MOVE_DOWN;
              dir_d   = 1'b0;
            end else begin
              state_d = MOVE_UP;
              dir_d   = 1'b1;
            end
          end
        end
      end

      MOVE_UP: begin
        // Calls for the floor being left are kept for a later pass
        pending_d = merged;
        if (FLOOR_TICK && (cur_floor_q != TOP_FLOOR)) begin
          cur_floor_d = floor_up;
          if (merged[floor_up]) begin
            state_d             = DOOR;
            timer_d             = DOOR_LOAD;
            pending_d[floor_up] = 1'b0;
          end
        end
      end

      MOVE_DOWN: begin
        pending_d = merged;
        if (FLOOR_TICK && (cur_floor_q != BOTTOM_FLOOR)) begin
          cur_floor_d = floor_down;
          if (merged[floor_down]) begin
            state_d               = DOOR;
            timer_d               = DOOR_LOAD;
            pending_d[floor_down] = 1'b0;
          end
        end
      end

      DOOR: begin
        if (req_here) begin
          // Another call at this floor keeps the door open a full period
          timer_d = DOOR_LOAD;
        end else begin
          pending_d = merged;
          if (timer_q <= TIMER_W'(1)) begin
            state_d = IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    motor_up_d   = (state_d == MOVE_UP);
    motor_down_d = (state_d == MOVE_DOWN);
    door_open_d  = (state_d == DOOR);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      cur_floor_q  <= '0;
      pending_q    <= '0;
      dir_q        <= 1'b1;
      timer_q      <= '0;
      motor_up_q   <= 1'b0;
      motor_down_q <= 1'b0;
      door_open_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_floor_q  <= cur_floor_d;
      pending_q    <= pending_d;
      dir_q        <= dir_d;
      timer_q      <= timer_d;
      motor_up_q   <= motor_up_d;
      motor_down_q <= motor_down_d;
      door_open_q  <= door_open_d;
    end
  end

  assign MOTOR_UP   = motor_up_q;
  assign MOTOR_DOWN = motor_down_q;
  assign DOOR_OPEN  = door_open_q;
  assign CUR_FLOOR  = cur_floor_q;
  assign PENDING    = pending_q;
  assign STATE      = state_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: directed scenarios with a cycle-tagged scoreboard.
// Stimulus queues the expected snapshot for each cycle; the monitor pops and
// compares on the falling edge.

module tb_elevator_scheduler;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;
  localparam logic [1:0] S_DOOR = 2'd3;

  logic       CLK;
  logic       RST;
  logic       REQ_VALID;
  logic [2:0] REQ_FLOOR;
  logic       FLOOR_TICK;
  logic       MOTOR_UP;
  logic       MOTOR_DOWN;
  logic       DOOR_OPEN;
  logic [2:0] CUR_FLOOR;
  logic [7:0] PENDING;
  logic [1:0] STATE;

  typedef struct {
    int         due;
    string      tag;
    logic [1:0] st;
    logic [2:0] fl;
    logic [7:0] pd;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   stim_cyc = 0;
  int   mon_cyc  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  elevator_scheduler #(.DOOR_CYCLES(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ_VALID  (REQ_VALID),
    .REQ_FLOOR  (REQ_FLOOR),
    .FLOOR_TICK (FLOOR_TICK),
    .MOTOR_UP   (MOTOR_UP),
    .MOTOR_DOWN (MOTOR_DOWN),
    .DOOR_OPEN  (DOOR_OPEN),
    .CUR_FLOOR  (CUR_FLOOR),
    .PENDING    (PENDING),
    .STATE      (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Monitor: compare every queued snapshot due at this falling edge
  always @(negedge CLK) begin
    mon_cyc++;
    while (sb_q.size() > 0 && sb_q[0].due <= mon_cyc) begin
      mon_e = sb_q.pop_front();
      n_checks++;
      if (mon_e.due != mon_cyc ||
          {STATE, CUR_FLOOR, PENDING, MOTOR_UP, MOTOR_DOWN, DOOR_OPEN} !==
          {mon_e.st, mon_e.fl, mon_e.pd, mon_e.st == S_UP, mon_e.st == S_DOWN, mon_e.st == S_DOOR}) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got state=%0d floor=%0d pending=%02h up=%0b down=%0b door=%0b, expected state=%0d floor=%0d pending=%02h up=%0b down=%0b door=%0b",
                 mon_e.tag, mon_cyc, STATE, CUR_FLOOR, PENDING, MOTOR_UP, MOTOR_DOWN, DOOR_OPEN,
                 mon_e.st, mon_e.fl, mon_e.pd, mon_e.st == S_UP, mon_e.st == S_DOWN, mon_e.st == S_DOOR);
      end
    end
  end

  // One clock of stimulus; the snapshot is what must be visible after its edge
  task automatic step(input logic rst, input logic rv, input logic [2:0] rf, input logic ft,
                      input string tag, input logic [1:0] st, input logic [2:0] fl,
                      input logic [7:0] pd);
    exp_t e;
    e.due = stim_cyc + 1;
    e.tag = tag;
    e.st  = st;
    e.fl  = fl;
    e.pd  = pd;
    sb_q.push_back(e);
    RST        = rst;
    REQ_VALID  = rv;
    REQ_FLOOR  = rf;
    FLOOR_TICK = ft;
    @(negedge CLK);
    stim_cyc++;
  endtask

  task automatic c_n(input string tag, input logic [1:0] st, input logic [2:0] fl, input logic [7:0] pd);
    step(1'b0, 1'b0, 3'd0, 1'b0, tag, st, fl, pd);
  endtask

  task automatic c_t(input string tag, input logic [1:0] st, input logic [2:0] fl, input logic [7:0] pd);
    step(1'b0, 1'b0, 3'd0, 1'b1, tag, st, fl, pd);
  endtask

  task automatic c_r(input logic [2:0] f, input string tag, input logic [1:0] st, input logic [2:0] fl, input logic [7:0] pd);
    step(1'b0, 1'b1, f, 1'b0, tag, st, fl, pd);
  endtask

  task automatic c_rt(input logic [2:0] f, input string tag, input logic [1:0] st, input logic [2:0] fl, input logic [7:0] pd);
    step(1'b0, 1'b1, f, 1'b1, tag, st, fl, pd);
  endtask

  initial begin
    RST        = 1'b1;
    REQ_VALID  = 1'b0;
    REQ_FLOOR  = 3'd0;
    FLOOR_TICK = 1'b0;

    // Reset, with a request and tick present while reset is held
    step(1'b1, 1'b0, 3'd0, 1'b0, "reset",        S_IDLE, 3'd0, 8'h00);
    step(1'b1, 1'b1, 3'd5, 1'b1, "reset_ignore", S_IDLE, 3'd0, 8'h00);

    // Scenario 1: request floor 3 from floor 0
    c_r (3'd3, "s1_req3",     S_IDLE, 3'd0, 8'h08);
    c_n (      "s1_start_up", S_UP,   3'd0, 8'h08);
    c_t (      "s1_floor1",   S_UP,   3'd1, 8'h08);
    c_n (      "s1_hold1",    S_UP,   3'd1, 8'h08);
    c_t (      "s1_floor2",   S_UP,   3'd2, 8'h08);
    c_t (      "s1_arrive3",  S_DOOR, 3'd3, 8'h00);
    c_n (      "s1_door2",    S_DOOR, 3'd3, 8'h00);
    c_t (      "s1_door3_tk", S_DOOR, 3'd3, 8'h00);
    c_n (      "s1_door4",    S_DOOR, 3'd3, 8'h00);
    c_n (      "s1_idle",     S_IDLE, 3'd3, 8'h00);

    // Scenario 2: at 3 going up, calls for 6 then 1
    c_r (3'd6, "s2_req6",     S_IDLE, 3'd3, 8'h40);
    c_r (3'd1, "s2_req1_up",  S_UP,   3'd3, 8'h42);
    c_t (      "s2_floor4",   S_UP,   3'd4, 8'h42);
    c_t (      "s2_floor5",   S_UP,   3'd5, 8'h42);
    c_t (      "s2_arrive6",  S_DOOR, 3'd6, 8'h02);
    c_n (      "s2_door2",    S_DOOR, 3'd6, 8'h02);
    c_n (      "s2_door3",    S_DOOR, 3'd6, 8'h02);
    c_n (      "s2_door4",    S_DOOR, 3'd6, 8'h02);
    c_n (      "s2_idle6",    S_IDLE, 3'd6, 8'h02);
    c_n (      "s2_start_dn", S_DOWN, 3'd6, 8'h02);
    c_t (      "s2_floor5d",  S_DOWN, 3'd5, 8'h02);
    c_t (      "s2_floor4d",  S_DOWN, 3'd4, 8'h02);
    c_t (      "s2_floor3d",  S_DOWN, 3'd3, 8'h02);
    c_t (      "s2_floor2d",  S_DOWN, 3'd2, 8'h02);
    c_t (      "s2_arrive1",  S_DOOR, 3'd1, 8'h00);
    c_n (      "s2_door1b",   S_DOOR, 3'd1, 8'h00);
    c_n (      "s2_door1c",   S_DOOR, 3'd1, 8'h00);
    c_n (      "s2_door1d",   S_DOOR, 3'd1, 8'h00);
    c_n (      "s2_idle1",    S_IDLE, 3'd1, 8'h00);

    // Scenario 3: park at floor 2, then call the floor the car is on
    c_r (3'd2, "s3_req2",     S_IDLE, 3'd1, 8'h04);
    c_n (      "s3_up",       S_UP,   3'd1, 8'h04);
    c_t (      "s3_arrive2",  S_DOOR, 3'd2, 8'h00);
    c_n (      "s3_d2",       S_DOOR, 3'd2, 8'h00);
    c_n (      "s3_d3",       S_DOOR, 3'd2, 8'h00);
    c_n (      "s3_d4",       S_DOOR, 3'd2, 8'h00);
    c_n (      "s3_idle2",    S_IDLE, 3'd2, 8'h00);
    c_r (3'd2, "s3_here_open",S_DOOR, 3'd2, 8'h00);
    c_n (      "s3_open2",    S_DOOR, 3'd2, 8'h00);
    c_n (      "s3_open3",    S_DOOR, 3'd2, 8'h00);
    c_r (3'd2, "s3_reload",   S_DOOR, 3'd2, 8'h00);
    c_n (      "s3_held2",    S_DOOR, 3'd2, 8'h00);
    c_n (      "s3_held3",    S_DOOR, 3'd2, 8'h00);
    c_n (      "s3_held4",    S_DOOR, 3'd2, 8'h00);
    c_n (      "s3_closed",   S_IDLE, 3'd2, 8'h00);

    // Scenario 4: call for the current floor while moving up is deferred
    c_r (3'd7, "s4_req7",     S_IDLE, 3'd2, 8'h80);
    c_n (      "s4_up",       S_UP,   3'd2, 8'h80);
    c_t (      "s4_floor3",   S_UP,   3'd3, 8'h80);
    c_t (      "s4_floor4",   S_UP,   3'd4, 8'h80);
    c_r (3'd4, "s4_req4_at4", S_UP,   3'd4, 8'h90);
    c_rt(3'd7, "s4_dup7",     S_UP,   3'd5, 8'h90);
    c_t (      "s4_floor6",   S_UP,   3'd6, 8'h90);
    c_t (      "s4_arrive7",  S_DOOR, 3'd7, 8'h10);
    c_t (      "s4_door_tk",  S_DOOR, 3'd7, 8'h10);
    c_n (      "s4_d3",       S_DOOR, 3'd7, 8'h10);
    c_n (      "s4_d4",       S_DOOR, 3'd7, 8'h10);
    c_n (      "s4_idle7",    S_IDLE, 3'd7, 8'h10);
    c_n (      "s4_down",     S_DOWN, 3'd7, 8'h10);
    c_t (      "s4_floor6d",  S_DOWN, 3'd6, 8'h10);
    c_t (      "s4_floor5d",  S_DOWN, 3'd5, 8'h10);
    c_t (      "s4_arrive4",  S_DOOR, 3'd4, 8'h00);
    c_n (      "s4_d4b",      S_DOOR, 3'd4, 8'h00);
    c_n (      "s4_d4c",      S_DOOR, 3'd4, 8'h00);
    c_n (      "s4_d4d",      S_DOOR, 3'd4, 8'h00);
    c_n (      "s4_idle4",    S_IDLE, 3'd4, 8'h00);

    // Scenario 5: request and tick for floor 5 in the same cycle
    c_r (3'd7, "s5_req7",     S_IDLE, 3'd4, 8'h80);
    c_n (      "s5_up",       S_UP,   3'd4, 8'h80);
    c_rt(3'd5, "s5_stop5",    S_DOOR, 3'd5, 8'h80);
    c_n (      "s5_d2",       S_DOOR, 3'd5, 8'h80);
    c_n (      "s5_d3",       S_DOOR, 3'd5, 8'h80);
    c_n (      "s5_d4",       S_DOOR, 3'd5, 8'h80);
    c_n (      "s5_idle5",    S_IDLE, 3'd5, 8'h80);
    c_n (      "s5_up2",      S_UP,   3'd5, 8'h80);
    c_t (      "s5_floor6",   S_UP,   3'd6, 8'h80);
    c_t (      "s5_arrive7",  S_DOOR, 3'd7, 8'h00);
    c_n (      "s5_d7b",      S_DOOR, 3'd7, 8'h00);
    c_n (      "s5_d7c",      S_DOOR, 3'd7, 8'h00);
    c_n (      "s5_d7d",      S_DOOR, 3'd7, 8'h00);
    c_n (      "s5_idle7",    S_IDLE, 3'd7, 8'h00);

    // Scenario 6: reset in the middle of a downward move
    c_r (3'd0, "s6_req0",     S_IDLE, 3'd7, 8'h01);
    c_n (      "s6_down",     S_DOWN, 3'd7, 8'h01);
    c_t (      "s6_floor6",   S_DOWN, 3'd6, 8'h01);
    c_t (      "s6_floor5",   S_DOWN, 3'd5, 8'h01);
    c_t (      "s6_floor4",   S_DOWN, 3'd4, 8'h01);
    step(1'b1, 1'b1, 3'd3, 1'b1, "s6_reset_mid", S_IDLE, 3'd0, 8'h00);
    step(1'b1, 1'b0, 3'd0, 1'b1, "s6_reset_hold", S_IDLE, 3'd0, 8'h00);
    c_t (      "s6_tick_idle0", S_IDLE, 3'd0, 8'h00);
    c_t (      "s6_no_wrap",    S_IDLE, 3'd0, 8'h00);
    c_r (3'd0, "s6_here0",      S_DOOR, 3'd0, 8'h00);
    c_n (      "s6_d2",         S_DOOR, 3'd0, 8'h00);
    c_n (      "s6_d3",         S_DOOR, 3'd0, 8'h00);
    c_n (      "s6_d4",         S_DOOR, 3'd0, 8'h00);
    c_n (      "s6_idle0",      S_IDLE, 3'd0, 8'h00);

    // Drain: every queued snapshot must have been consumed by the monitor
    REQ_VALID  = 1'b0;
    FLOOR_TICK = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d snapshots left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator_scheduler.md
ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 The block SHALL have one parameter: DOOR_CYCLES, default 16, number of cycles the door stays open per stop (legal range 1..255).
REQ-002 The block SHALL have these ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous active-high reset.
- REQ_VALID  input  1  floor request strobe from the keypad decoder.
- REQ_FLOOR  input  3  requested floor, 0..7, valid when REQ_VALID=1.
- FLOOR_TICK  input  1  one-cycle pulse from the motor drive on arrival at the adjacent floor.
- MOTOR_UP  output  1  drive car upward.
- MOTOR_DOWN  output  1  drive car downward.
- DOOR_OPEN  output  1  door open command.
- CUR_FLOOR  output  3  current car floor.
- PENDING  output  8  outstanding request bitmap; bit n means floor n.
- STATE  output  2  FSM state code: 0=IDLE, 1=MOVE_UP, 2=MOVE_DOWN, 3=DOOR.
REQ-003 All outputs SHALL be registered, or be decoded from registered state only.

Function
REQ-004 The block SHALL implement a SCAN scheduler with states IDLE, MOVE_UP, MOVE_DOWN and DOOR, plus a 1-bit direction register DIR (1=up).
REQ-005 Request capture: REQ_VALID=1 SHALL set PENDING[REQ_FLOOR] at the next edge, with these exceptions:
- In IDLE or DOOR with REQ_FLOOR==CUR_FLOOR, no bit is set. The block enters (IDLE) or stays in (DOOR) DOOR, and the door timer is reloaded to DOOR_CYCLES.
- A request for an already-pending floor has no additional effect.
REQ-006 In IDLE with PENDING!=0, the next state SHALL be:
- MOVE_UP if DIR=1 and any pending bit is above CUR_FLOOR;
- else MOVE_DOWN if any pending bit is below CUR_FLOOR;
- else MOVE_UP.
DIR SHALL be updated to match the chosen direction. The move is one cycle of latency after the request is visible in PENDING.
REQ-007 In IDLE with PENDING==0 and no request, the state SHALL remain IDLE.
REQ-008 MOTOR_UP=1 only in MOVE_UP, MOTOR_DOWN=1 only in MOVE_DOWN; the two SHALL never both be 1.
REQ-009 In MOVE_UP, on FLOOR_TICK: CUR_FLOOR SHALL increment by 1. If the merged bitmap (PENDING | same-cycle request) has the new floor's bit set:
- go to DOOR;
- clear that bit;
- load the door timer with DOOR_CYCLES.
Otherwise the state stays MOVE_UP.
REQ-010 MOVE_DOWN SHALL behave as REQ-009 with CUR_FLOOR decrementing.
REQ-011 FLOOR_TICK SHALL be ignored in IDLE and DOOR, in MOVE_UP at floor 7, and in MOVE_DOWN at floor 0. CUR_FLOOR SHALL never wrap.
REQ-012 In MOVE_UP/MOVE_DOWN, a request for CUR_FLOOR SHALL be stored in PENDING and serviced on a later pass.
REQ-013 DOOR:
- DOOR_OPEN=1 for exactly DOOR_CYCLES cycles (absent reloads), decrementing the timer each cycle.
- When the timer reaches 0, the next state is IDLE with DOOR_OPEN=0 and DIR preserved.
REQ-014 A tick and a request arriving in the same cycle SHALL both take effect in that cycle.

Reset
REQ-015 RST=1 at a rising edge SHALL force, regardless of current state (including mid-move or door open):
- STATE=IDLE, CUR_FLOOR=0, PENDING=0, DIR=1;
- MOTOR_UP=0, MOTOR_DOWN=0, DOOR_OPEN=0, door timer=0.
REQ-016 While RST=1, requests and ticks SHALL be ignored.

Verification
REQ-017 The bench SHALL use DOOR_CYCLES=4 and cover these scenarios:
- Reset, then REQ 3, then 3 FLOOR_TICKs -> MOTOR_UP from the 2nd cycle after the request; CUR_FLOOR 1,2,3; DOOR_OPEN 4 cycles; PENDING=0; STATE=IDLE.
- At floor 3 idle with DIR=1, requests 1 and 6 in consecutive cycles -> MOVE_UP to 6 first; door; then MOVE_DOWN to 1.
- Idle at floor 2, REQ 2 -> DOOR_OPEN next cycle for 4 cycles; PENDING unchanged. A repeat REQ 2 at door cycle 3 -> door held 4 more cycles.
- Moving up past floor 4 with PENDING=0x80, REQ 4 while CUR_FLOOR=4 -> car continues to 7; PENDING[4] stays set; afterwards the car returns down to 4.
- REQ 5 in the same cycle as the FLOOR_TICK reaching 5 -> stop at 5; PENDING[5]=0.
- RST asserted during MOVE_DOWN at floor 4 -> next cycle all outputs at reset values; extra FLOOR_TICKs have no effect; no wrap below 0.
